// File: rtl/world_to_pixel_pkg.sv
// world_to_pixel_pkg
// Shared graphics constants and types for the world <-> pixel mapping blocks.
// Holds the default screen geometry, world coordinate width, default zoom
// exponent, and the clamp helper used for both screen axes.
package world_to_pixel_pkg;

  localparam int DEFAULT_PIXEL_WIDTH  = 1280;
  localparam int DEFAULT_PIXEL_HEIGHT = 720;
  localparam int DEFAULT_WORLD_BITS   = 32;
  localparam int DEFAULT_SCALE_LEVEL  = 0;

  // Wide signed working width for screen-space arithmetic. Large enough for a
  // full-range world difference plus a moderate zoom-in shift and the
  // half-screen offset, so nothing wraps before clamping.
  localparam int CALC_BITS = 64;

  typedef logic signed [DEFAULT_WORLD_BITS-1:0]           world_coord_t;
  typedef logic [$clog2(DEFAULT_PIXEL_WIDTH)-1:0]          hcount_t;
  typedef logic [$clog2(DEFAULT_PIXEL_HEIGHT)-1:0]         vcount_t;
  typedef logic signed [CALC_BITS-1:0]                     calc_t;

  // Saturate a signed screen coordinate into [0, max_value].
  function automatic calc_t clamp_to_range(input calc_t value, input calc_t max_value);
    calc_t result;
    result = value;
    if (value < calc_t'(0)) begin
      result = calc_t'(0);
    end else if (value > max_value) begin
      result = max_value;
    end
    return result;
  endfunction

endpackage

// File: rtl/world_to_pixel.sv
// world_to_pixel
// Streaming world -> screen mapping. Each accepted point is offset by the
// latched camera, scaled by the zoom exponent, shifted to screen centre
// (y axis flipped), clamped per axis, and flagged as on/off screen.
// Two-stage valid/ready pipeline, 1 point/cycle, 2-cycle latency.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous reset, active-low
//   camera_x/y_in   camera centre, captured when camera_load_in is high
//   camera_load_in  write the camera register (points accepted this cycle
//                   still use the previous camera)
//   world_x/y_in    point to convert, qualified by valid_in
//   ready_out       block can accept a point this cycle
//   hcount_out      clamped pixel column
//   vcount_out      clamped pixel row
//   on_screen_out   point falls inside the visible frame
//   valid_out       output point valid, held until ready_in
module world_to_pixel
  import world_to_pixel_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT = DEFAULT_PIXEL_HEIGHT,
  parameter int WORLD_BITS   = DEFAULT_WORLD_BITS,
  parameter int SCALE_LEVEL  = DEFAULT_SCALE_LEVEL
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic signed [WORLD_BITS-1:0]     camera_x_in,
  input  logic signed [WORLD_BITS-1:0]     camera_y_in,
  input  logic                             camera_load_in,
  input  logic signed [WORLD_BITS-1:0]     world_x_in,
  input  logic signed [WORLD_BITS-1:0]     world_y_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic [$clog2(PIXEL_WIDTH)-1:0]   hcount_out,
  output logic [$clog2(PIXEL_HEIGHT)-1:0]  vcount_out,
  output logic                             on_screen_out,
  output logic                             valid_out,
  input  logic                             ready_in
);

  localparam int HBITS = $clog2(PIXEL_WIDTH);
  localparam int VBITS = $clog2(PIXEL_HEIGHT);
  // Only one of the two shifts is ever non-zero.
  localparam int SHR = (SCALE_LEVEL >= 0) ? SCALE_LEVEL : 0;
  localparam int SHL = (SCALE_LEVEL < 0) ? -SCALE_LEVEL : 0;
  // Zooming in grows the value, so the scaled width grows with it.
  localparam int SW  = WORLD_BITS + 1 + SHL;

  logic signed [WORLD_BITS-1:0] cam_x;
  logic signed [WORLD_BITS-1:0] cam_y;

  logic                         s1_valid;
  logic signed [WORLD_BITS:0]   s1_dx;
  logic signed [WORLD_BITS:0]   s1_dy;
  logic                         s2_valid;

  logic                         adv1;
  logic                         adv2;

  logic signed [SW-1:0]         sdx;
  logic signed [SW-1:0]         sdy;
  calc_t                        px;
  calc_t                        py;
  logic                         on_screen_next;

  // Stage advance: a stage may load when it is empty or its contents move on.
  always_comb begin
    adv2 = !s2_valid || ready_in;
    adv1 = !s1_valid || adv2;
  end

  assign ready_out = adv1;
  assign valid_out = s2_valid;

  // Camera register; in-flight points already carry their own differences,
  // so a reload only affects points accepted on later cycles.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cam_x <= '0;
      cam_y <= '0;
    end else if (camera_load_in) begin
      cam_x <= camera_x_in;
      cam_y <= camera_y_in;
    end
  end

  // Stage 1: camera-relative offset, one bit wider so it never wraps.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
    end else if (adv1) begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_dx <= (WORLD_BITS+1)'(world_x_in) - (WORLD_BITS+1)'(cam_x);
        s1_dy <= (WORLD_BITS+1)'(world_y_in) - (WORLD_BITS+1)'(cam_y);
      end
    end
  end

  // Scaling and screen placement. The arithmetic right shift floors toward
  // minus infinity, which keeps the mapping an exact inverse of pixel-to-world.
  always_comb begin
    sdx = (SW'(s1_dx) >>> SHR) <<< SHL;
    sdy = (SW'(s1_dy) >>> SHR) <<< SHL;
    px  = calc_t'(sdx) + calc_t'(PIXEL_WIDTH / 2);
    py  = calc_t'(PIXEL_HEIGHT / 2) - calc_t'(sdy);
    on_screen_next = (px >= calc_t'(0)) && (px < calc_t'(PIXEL_WIDTH)) &&
                     (py >= calc_t'(0)) && (py < calc_t'(PIXEL_HEIGHT));
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s2_valid      <= 1'b0;
      hcount_out    <= '0;
      vcount_out    <= '0;
      on_screen_out <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        hcount_out    <= HBITS'(clamp_to_range(px, calc_t'(PIXEL_WIDTH - 1)));
        vcount_out    <= VBITS'(clamp_to_range(py, calc_t'(PIXEL_HEIGHT - 1)));
        on_screen_out <= on_screen_next;
      end
    end
  end

endmodule

// File: tb/tb_world_to_pixel.sv
// tb_world_to_pixel
// Directed and randomized checks of world_to_pixel at three zoom levels
// (0, +1, -1). A reference model computes expected pixels straight from the
// mapping rules using 64-bit integer arithmetic and floor division; a
// scoreboard matches every accepted point to every delivered point in order.
module tb_world_to_pixel;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        o;
  } exp_t;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [31:0] camera_x_in;
  logic signed [31:0] camera_y_in;
  logic               camera_load_in;
  logic signed [31:0] world_x_in;
  logic signed [31:0] world_y_in;
  logic               valid_in;
  logic               ready_in;

  logic [10:0] hc0, hc1, hc2;
  logic [9:0]  vc0, vc1, vc2;
  logic        os0, os1, os2;
  logic        vo0, vo1, vo2;
  logic        ro0, ro1, ro2;

  logic [10:0] hc [3];
  logic [9:0]  vc [3];
  logic        os [3];
  logic        vo [3];
  logic        ro [3];

  assign hc[0] = hc0;  assign hc[1] = hc1;  assign hc[2] = hc2;
  assign vc[0] = vc0;  assign vc[1] = vc1;  assign vc[2] = vc2;
  assign os[0] = os0;  assign os[1] = os1;  assign os[2] = os2;
  assign vo[0] = vo0;  assign vo[1] = vo1;  assign vo[2] = vo2;
  assign ro[0] = ro0;  assign ro[1] = ro1;  assign ro[2] = ro2;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t   exp_q [3][$];
  longint cam_x_m = 0;
  longint cam_y_m = 0;

  always #5 clk_in = ~clk_in;

  world_to_pixel #(.SCALE_LEVEL(0)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .camera_x_in(camera_x_in), .camera_y_in(camera_y_in), .camera_load_in(camera_load_in),
    .world_x_in(world_x_in), .world_y_in(world_y_in), .valid_in(valid_in), .ready_out(ro0),
    .hcount_out(hc0), .vcount_out(vc0), .on_screen_out(os0), .valid_out(vo0), .ready_in(ready_in)
  );

  world_to_pixel #(.SCALE_LEVEL(1)) dut_s1 (
    .clk_in(clk_in), .rst_in(rst_in),
    .camera_x_in(camera_x_in), .camera_y_in(camera_y_in), .camera_load_in(camera_load_in),
    .world_x_in(world_x_in), .world_y_in(world_y_in), .valid_in(valid_in), .ready_out(ro1),
    .hcount_out(hc1), .vcount_out(vc1), .on_screen_out(os1), .valid_out(vo1), .ready_in(ready_in)
  );

  world_to_pixel #(.SCALE_LEVEL(-1)) dut_m1 (
    .clk_in(clk_in), .rst_in(rst_in),
    .camera_x_in(camera_x_in), .camera_y_in(camera_y_in), .camera_load_in(camera_load_in),
    .world_x_in(world_x_in), .world_y_in(world_y_in), .valid_in(valid_in), .ready_out(ro2),
    .hcount_out(hc2), .vcount_out(vc2), .on_screen_out(os2), .valid_out(vo2), .ready_in(ready_in)
  );

  function automatic int scaleOf(int idx);
    return (idx == 0) ? 0 : ((idx == 1) ? 1 : -1);
  endfunction

  // One pixel spans 2**scale world units: floor-divide when zooming out,
  // multiply when zooming in.
  function automatic longint scaleBy(longint val, int scale);
    longint d;
    longint q;
    if (scale >= 0) begin
      d = longint'(1) << scale;
      q = val / d;
      if ((val % d != 0) && (val < 0)) q = q - 1;
    end else begin
      q = val * (longint'(1) << (-scale));
    end
    return q;
  endfunction

  function automatic exp_t refPixel(int scale, longint wx, longint wy, longint cx, longint cy);
    longint px;
    longint py;
    exp_t   r;
    px  = scaleBy(wx - cx, scale) + 640;
    py  = 360 - scaleBy(wy - cy, scale);
    r.o = (px >= 0) && (px < 1280) && (py >= 0) && (py < 720);
    r.h = 11'((px < 0) ? 0 : ((px > 1279) ? 1279 : px));
    r.v = 10'((py < 0) ? 0 : ((py > 719) ? 719 : py));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: record accepted points with the camera in force at accept
  // time, then compare every delivered point in order.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      cam_x_m = 0;
      cam_y_m = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (vo[i] && ready_in) begin
          if (exp_q[i].size() == 0) begin
            checkOutput($sformatf("spurious_out%0d", i), vo[i], 0);
          end else begin
            e = exp_q[i].pop_front();
            checkOutput($sformatf("sb_h%0d", i), hc[i], e.h);
            checkOutput($sformatf("sb_v%0d", i), vc[i], e.v);
            checkOutput($sformatf("sb_on%0d", i), os[i], e.o);
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (valid_in && ro[i])
          exp_q[i].push_back(refPixel(scaleOf(i), world_x_in, world_y_in, cam_x_m, cam_y_m));
      end
      if (camera_load_in) begin
        cam_x_m = camera_x_in;
        cam_y_m = camera_y_in;
      end
    end
  end

  // Present one point (optionally with a camera load) and hold it until
  // accepted; returns just after the accepting edge.
  task automatic applyStimulus(input int wx, input int wy, input logic load, input int cx, input int cy);
    bit got;
    got            = 0;
    world_x_in     = wx;
    world_y_in     = wy;
    valid_in       = 1'b1;
    camera_load_in = load;
    camera_x_in    = cx;
    camera_y_in    = cy;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (ro[0]) begin
        got = 1;
        break;
      end
      @(posedge clk_in); #1;
    end
    if (!got) checkOutput("accept_timeout", ro[0], 1);
    @(posedge clk_in); #1;
    valid_in       = 1'b0;
    camera_load_in = 1'b0;
  endtask

  task automatic waitOutput();
    bit got;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (vo[0]) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("out_timeout", vo[0], 1);
  endtask

  task automatic loadCamera(input int cx, input int cy);
    camera_x_in    = cx;
    camera_y_in    = cy;
    camera_load_in = 1'b1;
    @(posedge clk_in); #1;
    camera_load_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [10:0] held_h;
    rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; camera_load_in = 1'b0;
    camera_x_in = 0; camera_y_in = 0; world_x_in = 0; world_y_in = 0;

    // Reset state
    @(posedge clk_in); @(negedge clk_in);
    checkOutput("rst_valid", vo[0], 0);
    checkOutput("rst_h", hc[0], 0);
    checkOutput("rst_v", vc[0], 0);
    checkOutput("rst_on", os[0], 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    checkOutput("ready_after_rst", ro[0], 1);
    @(posedge clk_in); #1;

    // Latency: two edges from accept to valid_out
    applyStimulus(0, 0, 1'b0, 0, 0);
    @(negedge clk_in);
    checkOutput("lat_not_early", vo[0], 0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    checkOutput("lat_valid", vo[0], 1);
    checkOutput("origin_h", hc[0], 640);
    checkOutput("origin_v", vc[0], 360);
    checkOutput("origin_on", os[0], 1);
    @(posedge clk_in); #1;

    // Corners and clamping
    applyStimulus(-640, 360, 1'b0, 0, 0); waitOutput();
    checkOutput("tl_h", hc[0], 0); checkOutput("tl_v", vc[0], 0); checkOutput("tl_on", os[0], 1);
    @(posedge clk_in); #1;
    applyStimulus(639, -359, 1'b0, 0, 0); waitOutput();
    checkOutput("br_h", hc[0], 1279); checkOutput("br_v", vc[0], 719); checkOutput("br_on", os[0], 1);
    @(posedge clk_in); #1;
    applyStimulus(640, 0, 1'b0, 0, 0); waitOutput();
    checkOutput("right_h", hc[0], 1279); checkOutput("right_v", vc[0], 360); checkOutput("right_on", os[0], 0);
    @(posedge clk_in); #1;
    applyStimulus(-700, -1000, 1'b0, 0, 0); waitOutput();
    checkOutput("far_h", hc[0], 0); checkOutput("far_v", vc[0], 719); checkOutput("far_on", os[0], 0);
    @(posedge clk_in); #1;

    // Zoom levels
    applyStimulus(1, 0, 1'b0, 0, 0); waitOutput();
    checkOutput("zin_h", hc[2], 642);
    checkOutput("zero_h", hc[0], 641);
    checkOutput("zout_h", hc[1], 640);
    @(posedge clk_in); #1;
    loadCamera(10, -4);
    applyStimulus(7, -4, 1'b0, 0, 0); waitOutput();
    checkOutput("zout_floor_h", hc[1], 638);
    checkOutput("zout_floor_v", vc[1], 360);
    checkOutput("cam_h", hc[0], 637);
    @(posedge clk_in); #1;

    // Camera load in the same cycle as an accept uses the old camera
    loadCamera(0, 0);
    applyStimulus(100, 0, 1'b1, 100, 0);
    applyStimulus(100, 0, 1'b0, 0, 0);
    waitOutput();
    checkOutput("cam_old_h", hc[0], 740);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    checkOutput("cam_new_valid", vo[0], 1);
    checkOutput("cam_new_h", hc[0], 640);
    @(posedge clk_in); #1;
    repeat (3) @(posedge clk_in); #1;

    // Backpressure: A,B fill the pipe, C waits, outputs hold
    ready_in = 1'b0; world_y_in = 0; valid_in = 1'b1;
    world_x_in = 101; @(posedge clk_in); #1;
    world_x_in = 102; @(posedge clk_in); #1;
    world_x_in = 103;
    @(negedge clk_in);
    checkOutput("bp_ready_drop", ro[0], 0);
    checkOutput("bp_valid", vo[0], 1);
    checkOutput("bp_head_h", hc[0], 641);
    held_h = hc[0];
    @(posedge clk_in); #1;
    @(negedge clk_in);
    checkOutput("bp_ready_still", ro[0], 0);
    checkOutput("bp_hold_h", hc[0], held_h);
    checkOutput("bp_hold_valid", vo[0], 1);
    @(posedge clk_in); #1;
    ready_in = 1'b1;
    @(negedge clk_in);
    checkOutput("bp_ready_back", ro[0], 1);
    @(posedge clk_in); #1;
    world_x_in = 104; @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk_in); #1;
    @(negedge clk_in);
    checkOutput("bp_drained", exp_q[0].size(), 0);
    @(posedge clk_in); #1;

    // Reset with two points in flight
    applyStimulus(5, 5, 1'b0, 0, 0);
    applyStimulus(6, 6, 1'b0, 0, 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    checkOutput("flush_valid0", vo[0], 0);
    checkOutput("flush_valid1", vo[1], 0);
    checkOutput("flush_valid2", vo[2], 0);
    @(posedge clk_in); #1;
    applyStimulus(0, 0, 1'b0, 0, 0); waitOutput();
    checkOutput("post_rst_h", hc[0], 640);
    checkOutput("post_rst_v", vc[0], 360);
    @(posedge clk_in); #1;

    // Randomized traffic, backpressure and camera reloads
    for (int c = 0; c < 400; c++) begin
      valid_in       = ($urandom_range(0, 9) < 7);
      ready_in       = ($urandom_range(0, 3) != 0);
      camera_load_in = ($urandom_range(0, 9) == 0);
      camera_x_in    = int'($urandom_range(0, 2000)) - 1000;
      camera_y_in    = int'($urandom_range(0, 2000)) - 1000;
      if ($urandom_range(0, 7) == 0) begin
        world_x_in = $urandom;
        world_y_in = $urandom;
      end else begin
        world_x_in = int'($urandom_range(0, 4000)) - 2000;
        world_y_in = int'($urandom_range(0, 3000)) - 1500;
      end
      @(posedge clk_in); #1;
    end
    valid_in = 1'b0; ready_in = 1'b1; camera_load_in = 1'b0;
    repeat (6) @(posedge clk_in); #1;
    @(negedge clk_in);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("rand_drained%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
